uart_hex_tx: RTL and testbench

//  Upstream feeder for the UART transmitter. Accepts a binary word and emits it as

---
 rtl/uart_hex_tx.sv | 101 ++++++++++
 tb/tb_uart_hex_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_tx.sv
// Prints a 4*DIGITS-bit word as ASCII hex, MSB nibble first, with optional CR LF.
// First tx_valid lands two edges after accept; each character waits for tx_ready, and in_ready stays low until the word is fully handed off.
module uart_hex_tx #(
  parameter int DIGITS = 8,
  parameter bit UPPER  = 1'b1,
  parameter bit CRLF   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy
);

  localparam int W      = 4 * DIGITS;
  localparam int NCHARS = DIGITS + (CRLF ? 2 : 0);
  localparam int CW     = $clog2(NCHARS + 1);
  localparam logic [CW-1:0] DIG_C = CW'(DIGITS);
  localparam logic [CW-1:0] NCH_C = CW'(NCHARS);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD, S_WAIT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    sreg;
  logic [3:0]      nib;
  logic [7:0]      ch;

  assign in_ready = (state == S_IDLE);
  assign nib      = sreg[W-1 -: 4];

  // Character selected by the counter: digits first, then CR, then LF.
  always_comb begin
    ch = 8'h00;
    if (cnt < DIG_C) begin
      if (nib <= 4'd9) ch = 8'h30 + {4'h0, nib};
      else             ch = (UPPER ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
    end else if (cnt == DIG_C) begin
      ch = 8'h0D;
    end else begin
      ch = 8'h0A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      sreg     <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tx_valid <= 1'b0;
          if (in_valid) begin
            sreg  <= in_data;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b1;
            tx_data  <= ch;
            cnt      <= cnt + 1'b1;
            if (cnt < DIG_C) sreg <= sreg << 4;
            state    <= S_HOLD;
          end else begin
            tx_valid <= 1'b0;
          end
        end
        // The transmitter's ready is registered and lags the strobe by a cycle,
        // so it is deliberately ignored here.
        S_HOLD: begin
          tx_valid <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          tx_valid <= 1'b0;
          if (tx_ready) begin
            if (cnt == NCH_C) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              state <= S_SEND;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Scoreboarded bench: default-parameter instance (a) and DIGITS=4/lowercase/no-CRLF instance (b).
module tb_uart_hex_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data_a = '0;
  logic        in_valid_a = 1'b0;
  logic        in_ready_a, tx_valid_a, busy_a;
  logic [7:0]  tx_data_a;
  logic        tx_ready_a;
  logic [15:0] in_data_b = '0;
  logic        in_valid_b = 1'b0;
  logic        in_ready_b, tx_valid_b, busy_b;
  logic [7:0]  tx_data_b;
  logic        tx_ready_b;

  int total = 0;
  int bad   = 0;
  int pulses_a = 0, pulses_b = 0;
  bit prev_a = 0, prev_b = 0;
  bit hold_a = 0;
  int cnt_a = 0, cnt_b = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always #5 clk = ~clk;

  uart_hex_tx #(.DIGITS(8), .UPPER(1'b1), .CRLF(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .busy(busy_a));

  uart_hex_tx #(.DIGITS(4), .UPPER(1'b0), .CRLF(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .busy(busy_b));

  // Transmitter stand-ins: ready is registered, drops the edge after a strobe, recovers later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready_a <= 1'b1; cnt_a <= 0;
    end else if (tx_valid_a && tx_ready_a) begin
      tx_ready_a <= 1'b0; cnt_a <= 5;
    end else if (cnt_a != 0) begin
      cnt_a <= cnt_a - 1;
    end else begin
      tx_ready_a <= !hold_a;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready_b <= 1'b1; cnt_b <= 0;
    end else if (tx_valid_b && tx_ready_b) begin
      tx_ready_b <= 1'b0; cnt_b <= 3;
    end else if (cnt_b != 0) begin
      cnt_b <= cnt_b - 1;
    end else begin
      tx_ready_b <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitors: pop expected byte on every strobe.
  always @(negedge clk) begin
    if (rst_n && tx_valid_a) begin
      chk("a_valid_while_ready", {31'b0, tx_ready_a}, 32'd1);
      chk("a_no_back_to_back", {31'b0, prev_a}, 32'd0);
      if (qa.size() == 0) chk("a_unexpected_char", {24'b0, tx_data_a}, 32'hFFFF);
      else chk("a_char", {24'b0, tx_data_a}, {24'b0, qa.pop_front()});
      pulses_a++;
    end
    prev_a = rst_n && tx_valid_a;
  end

  always @(negedge clk) begin
    if (rst_n && tx_valid_b) begin
      chk("b_valid_while_ready", {31'b0, tx_ready_b}, 32'd1);
      chk("b_no_back_to_back", {31'b0, prev_b}, 32'd0);
      if (qb.size() == 0) chk("b_unexpected_char", {24'b0, tx_data_b}, 32'hFFFF);
      else chk("b_char", {24'b0, tx_data_b}, {24'b0, qb.pop_front()});
      pulses_b++;
    end
    prev_b = rst_n && tx_valid_b;
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n <= 4'd9) ? 8'h30 + {4'h0, n} : 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic push_word_a(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) qa.push_back(hexc(w[i*4 +: 4]));
    qa.push_back(8'h0D);
    qa.push_back(8'h0A);
  endtask

  task automatic offer_a(input logic [31:0] w);
    int n = 0;
    while (!in_ready_a && n < 2000) begin @(negedge clk); n++; end
    chk("a_offer_timeout", {31'b0, in_ready_a}, 32'd1);
    in_data_a = w; in_valid_a = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0;
  endtask

  task automatic drain_a(input string name);
    int n = 0;
    while ((qa.size() != 0 || busy_a) && n < 3000) begin @(negedge clk); n++; end
    chk({name, "_drain_timeout"}, n, n < 3000 ? n : 0);
    chk({name, "_busy_end"}, {31'b0, busy_a}, 32'd0);
    chk({name, "_in_ready_end"}, {31'b0, in_ready_a}, 32'd1);
  endtask

  logic [7:0] t1 [10] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
  logic [7:0] t2 [10] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h41, 8'h0D, 8'h0A};
  logic [7:0] t3 [4]  = '{8'h63, 8'h30, 8'h66, 8'h65};

  initial begin
    int p0, n;
    #12;
    chk("rst_tx_valid", {31'b0, tx_valid_a}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data_a}, 32'd0);
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready_a}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // T1
    p0 = pulses_a;
    foreach (t1[i]) qa.push_back(t1[i]);
    offer_a(32'hDEADBEEF);
    chk("t1_busy_after_accept", {31'b0, busy_a}, 32'd1);
    drain_a("t1");
    chk("t1_pulses", pulses_a - p0, 32'd10);

    // T2
    foreach (t2[i]) qa.push_back(t2[i]);
    offer_a(32'h0000000A);
    drain_a("t2");

    // T3
    foreach (t3[i]) qb.push_back(t3[i]);
    in_data_b = 16'hC0FE; in_valid_b = 1'b1;
    @(negedge clk); in_valid_b = 1'b0;
    n = 0;
    while ((qb.size() != 0 || busy_b) && n < 2000) begin @(negedge clk); n++; end
    chk("t3_busy_end", {31'b0, busy_b}, 32'd0);
    repeat (10) @(negedge clk);
    chk("t3_pulses", pulses_b, 32'd4);

    // T4: in_valid held high across two words
    p0 = pulses_a;
    push_word_a(32'h12345678);
    in_data_a = 32'h12345678; in_valid_a = 1'b1;
    @(negedge clk);
    in_data_a = 32'h9ABCDEF0;
    chk("t4_in_ready_busy", {31'b0, in_ready_a}, 32'd0);
    n = 0;
    while (!in_ready_a && n < 2000) begin @(negedge clk); n++; end
    chk("t4_first_done_at_ready", pulses_a - p0, 32'd10);
    push_word_a(32'h9ABCDEF0);
    @(negedge clk); in_valid_a = 1'b0;
    drain_a("t4");
    chk("t4_pulses", pulses_a - p0, 32'd20);

    // T5: transmitter stalled for 50 cycles
    p0 = pulses_a;
    hold_a = 1'b1;
    repeat (2) @(negedge clk);
    push_word_a(32'h13579BDF);
    offer_a(32'h13579BDF);
    repeat (50) @(negedge clk);
    chk("t5_no_strobe_stalled", pulses_a - p0, 32'd0);
    chk("t5_busy_stalled", {31'b0, busy_a}, 32'd1);
    hold_a = 1'b0;
    drain_a("t5");

    // T6: reset mid-word
    p0 = pulses_a;
    push_word_a(32'hDEADBEEF);
    offer_a(32'hDEADBEEF);
    n = 0;
    while (pulses_a - p0 < 3 && n < 2000) begin @(negedge clk); n++; end
    rst_n = 1'b0; in_valid_a = 1'b1; in_data_a = 32'h11111111;
    qa.delete();
    #1;
    chk("t6_rst_tx_valid", {31'b0, tx_valid_a}, 32'd0);
    chk("t6_rst_busy", {31'b0, busy_a}, 32'd0);
    chk("t6_rst_in_ready", {31'b0, in_ready_a}, 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; in_valid_a = 1'b0;
    @(negedge clk);
    chk("t6_not_captured_in_reset", {31'b0, busy_a}, 32'd0);
    p0 = pulses_a;
    push_word_a(32'hCAFE0123);
    offer_a(32'hCAFE0123);
    drain_a("t6");
    chk("t6_pulses_after", pulses_a - p0, 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    bad++;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
